conv_enc_k7: RTL and testbench

Rate-1/2, constraint-length-7 convolutional encoder, generators G0 = 171 (octal), G1 = 133 (octal), matching the 64-state branch-metric/ACS decoder path. Accepts one information bit per handshake and emits one coded pair per handshake, with the pair bit order the decoder's branch-metric units expect on their received-pair input. When enabled, it appends six zero tail bits per frame so the decoder traceback terminates in state 0. The block sits on the transmit/test side and produces stimulus and loopback traffic for the decoder.

---
 rtl/conv_enc_k7.sv | 168 ++++++++++++++++
 tb/tb_conv_enc_k7.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_enc_k7.sv
// conv_enc_k7: rate-1/2, K=7 convolutional encoder (G0 = 171 octal, G1 = 133 octal)
// with a single-entry valid/ready output register.
//
// Build option: define CONV_ENC_TAIL_EN to append six zero tail bits after every
// frame so the encoder (and the decoder traceback) ends each frame in state 0.
// Without it, in_last passes straight through to out_last and the shift
// register carries across frame boundaries.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   in_bit_i / in_last_i valid
//   in_ready_o   encoder accepts the input beat this cycle
//   in_bit_i     information bit
//   in_last_i    final information bit of the frame
//   out_valid_o  out_pair_o valid
//   out_ready_i  downstream accepts out_pair_o this cycle
//   out_pair_o   [1] = G0 parity, [0] = G1 parity
//   out_last_o   final coded pair of the frame
//   frame_cnt_o  completed-frame count, wraps at 16 bits
//
// state  | meaning
// -------+------------------------------------------------------------
// S_DATA | accepting information bits, one coded pair per accepted beat
// S_TAIL | input stalled, encoding six zero tail bits (tail build only)

module conv_enc_k7 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_bit_i,
  input  logic        in_last_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [1:0]  out_pair_o,
  output logic        out_last_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [6:0] G0 = 7'b1111001;
  localparam logic [6:0] G1 = 7'b1011011;

  // Window is {current bit, sr[5] (newest history) ... sr[0] (oldest)}.
  function automatic logic [1:0] encode(input logic b, input logic [5:0] sr);
    logic [6:0] w;
    w = {b, sr};
    return {^(w & G0), ^(w & G1)};
  endfunction

  logic [5:0]  sr_q, sr_d;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  out_pair_q, out_pair_d;
  logic        out_last_q, out_last_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic {
    S_DATA = 1'b0,
    S_TAIL = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] tail_cnt_q, tail_cnt_d;
`endif

  logic load_ok;
  logic enc_en;
  logic enc_bit;

  // The output register may be (re)loaded when empty or being drained this cycle.
  assign load_ok = !out_valid_q || out_ready_i;

  always_comb begin
    in_ready_o  = 1'b0;
    enc_en      = 1'b0;
    enc_bit     = 1'b0;
    sr_d        = sr_q;
    out_valid_d = out_valid_q && !out_ready_i;
    out_pair_d  = out_pair_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;

    if (out_valid_q && out_ready_i && out_last_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

`ifdef CONV_ENC_TAIL_EN
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;

    case (state_q)
      S_DATA: begin
        in_ready_o = load_ok;
        if (in_valid_i && load_ok) begin
          enc_en     = 1'b1;
          enc_bit    = in_bit_i;
          out_last_d = 1'b0;
          if (in_last_i) begin
            state_d    = S_TAIL;
            tail_cnt_d = 3'd0;
          end
        end
      end
      S_TAIL: begin
        if (load_ok) begin
          enc_en     = 1'b1;
          enc_bit    = 1'b0;
          out_last_d = (tail_cnt_q == 3'd5);
          if (tail_cnt_q == 3'd5) begin
            state_d    = S_DATA;
            tail_cnt_d = 3'd0;
          end else begin
            tail_cnt_d = tail_cnt_q + 3'd1;
          end
        end
      end
    endcase
`else
    in_ready_o = load_ok;
    if (in_valid_i && load_ok) begin
      enc_en     = 1'b1;
      enc_bit    = in_bit_i;
      out_last_d = in_last_i;
    end
`endif

    if (enc_en) begin
      out_valid_d = 1'b1;
      out_pair_d  = encode(enc_bit, sr_q);
      sr_d        = {enc_bit, sr_q[5:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_pair_q  <= '0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      out_pair_q  <= out_pair_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef CONV_ENC_TAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_DATA;
      tail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end
`endif

  assign out_valid_o = out_valid_q;
  assign out_pair_o  = out_pair_q;
  assign out_last_o  = out_last_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_conv_enc_k7.sv
// Testbench for conv_enc_k7: directed impulse / zero-frame / reset tables plus
// random traffic with random back-pressure against a bit-history reference model.
// Works for both builds (CONV_ENC_TAIL_EN defined or not).

module tb_conv_enc_k7;

`ifdef CONV_ENC_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  localparam logic [6:0] G0 = 7'b1111001;
  localparam logic [6:0] G1 = 7'b1011011;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_pair;
  logic        out_last;
  logic [15:0] frame_cnt;

  conv_enc_k7 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_bit_i    (in_bit),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_pair_o  (out_pair),
    .out_last_o  (out_last),
    .frame_cnt_o (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] pair;
    logic       last;
  } exp_t;

  bit          hist[$];     // hist[0] = most recently encoded bit
  exp_t        expq[$];
  int          tail_rem;
  logic [15:0] m_frames;
  logic        stall_prev;
  logic [1:0]  stall_pair;
  logic        stall_last;

  // Parity = XOR over taps of (generator tap k steps back) & (bit k steps back).
  function automatic logic [1:0] ref_encode(input bit b);
    logic [6:0] g0m;
    logic [6:0] g1m;
    bit p0;
    bit p1;
    bit t;
    g0m = G0;
    g1m = G1;
    p0 = 1'b0;
    p1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) t = b;
      else if (k - 1 < hist.size()) t = hist[k-1];
      else t = 1'b0;
      p0 ^= g0m[6-k] & t;
      p1 ^= g1m[6-k] & t;
    end
    hist.push_front(b);
    if (hist.size() > 6) void'(hist.pop_back());
    return {p0, p1};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin : mon
      logic ld;
      exp_t e;
      chk("frame_cnt", frame_cnt, m_frames);
      chk("out_valid", out_valid, expq.size() != 0);
      if (stall_prev) begin
        chk("stall_pair", out_pair, stall_pair);
        chk("stall_last", out_last, stall_last);
      end
      ld = !out_valid || out_ready;
      chk("in_ready", in_ready, ld && (tail_rem == 0));
      if (out_valid && out_ready && expq.size() != 0) begin
        e = expq.pop_front();
        chk("pair", out_pair, e.pair);
        chk("last", out_last, e.last);
        if (e.last) m_frames++;
      end
      if (tail_rem > 0) begin
        if (ld) tail_rem--;
      end else if (in_valid && in_ready) begin
        if (TAIL_EN && in_last) begin
          expq.push_back({ref_encode(in_bit), 1'b0});
          for (int i = 0; i < 6; i++) expq.push_back({ref_encode(1'b0), i == 5});
          tail_rem = 6;
        end else begin
          expq.push_back({ref_encode(in_bit), TAIL_EN ? 1'b0 : in_last});
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_pair = out_pair;
      stall_last = out_last;
    end
  end

  // ---------------- random back-pressure ----------------
  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  end

  // ---------------- directed table ----------------
  typedef struct packed {
    logic       v;
    logic       b;
    logic       l;
    logic       rdy;
    logic       ov;
    logic [1:0] pair;
    logic       last;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic b, input logic l, input logic rdy,
                              input logic ov, input logic [1:0] pair, input logic last);
    tbl.push_back('{v: v, b: b, l: l, rdy: rdy, ov: ov, pair: pair, last: last});
  endfunction

  task automatic do_reset();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    hist.delete();
    expq.delete();
    tail_rem = 0;
    m_frames = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pair", out_pair, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Impulse response; out_ready held high. Called at posedge+1 after reset.
  task automatic run_impulse(input string tag);
    tbl.delete();
    if (TAIL_EN) begin
      add(1, 1, 1, 1, 1, 2'b11, 0);
      add(0, 0, 0, 0, 1, 2'b10, 0);
      add(0, 0, 0, 0, 1, 2'b11, 0);
      add(0, 0, 0, 0, 1, 2'b11, 0);
      add(0, 0, 0, 0, 1, 2'b00, 0);
      add(0, 0, 0, 0, 1, 2'b01, 0);
      add(0, 0, 0, 0, 1, 2'b11, 1);
      add(0, 0, 0, 1, 0, 2'b00, 0);
    end else begin
      add(1, 1, 0, 1, 1, 2'b11, 0);
      add(1, 0, 0, 1, 1, 2'b10, 0);
      add(1, 0, 0, 1, 1, 2'b11, 0);
      add(1, 0, 0, 1, 1, 2'b11, 0);
      add(1, 0, 0, 1, 1, 2'b00, 0);
      add(1, 0, 0, 1, 1, 2'b01, 0);
      add(1, 0, 0, 1, 1, 2'b11, 0);
      add(1, 0, 0, 1, 1, 2'b00, 0);
      add(1, 0, 1, 1, 1, 2'b00, 1);
      add(0, 0, 0, 1, 0, 2'b00, 0);
    end
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      in_bit   = tbl[i].b;
      in_last  = tbl[i].l;
      #1;
      chk({tag, "_in_ready"}, in_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk({tag, "_out_valid"}, out_valid, tbl[i].ov);
      if (tbl[i].ov) begin
        chk({tag, "_out_pair"}, out_pair, tbl[i].pair);
        chk({tag, "_out_last"}, out_last, tbl[i].last);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_frame_cnt"}, frame_cnt, 1);
  endtask

  task automatic send_beat(input logic b, input logic l);
    int   n;
    logic acc;
    n        = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) fail("send_beat");
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   np;
    int   nz;
    int   lastidx;
    int   low;
    int   sent;
    int   bits;
    int   n;
    logic acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tail_rem  = 0;
    m_frames  = '0;

    do_reset();
    run_impulse("impulse");

    // All-zero frame of 20 bits, in_valid held high, out_ready high.
    np = 0; nz = 0; lastidx = 0; low = 0; sent = 0;
    in_valid = 1'b1;
    in_bit   = 1'b0;
    in_last  = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (!in_ready) low++;
      if (out_valid && out_ready) begin
        np++;
        if (out_pair != 2'b00) nz++;
        if (out_last) lastidx = np;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        in_last = (sent == 19);
        if (sent == 20) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("zero_pairs", np, TAIL_EN ? 26 : 20);
    chk("zero_nonzero", nz, 0);
    chk("zero_last_idx", lastidx, TAIL_EN ? 26 : 20);
    chk("zero_ready_low", low, TAIL_EN ? 6 : 0);
    chk("zero_frame_cnt", frame_cnt, 2);

    // Random frames with random gaps and back-pressure.
    rand_rdy = 1'b1;
    bits = 0;
    while (bits < 1000) begin
      int len;
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send_beat(1'($urandom_range(0, 1)), j == len - 1);
        bits++;
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((out_valid || expq.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail("drain");
    chk("drain_queue", expq.size(), 0);
    chk("drain_out_valid", out_valid, 0);
    chk("random_frame_cnt", frame_cnt, m_frames);

    // Reset in the middle of a frame, then the impulse must look like a fresh start.
    rand_rdy = 1'b1;
    for (int j = 0; j < 10; j++) send_beat(1'($urandom_range(0, 1)), 1'b0);
    do_reset();
    run_impulse("post_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
